load_store_unit: RTL and testbench

Multicycle data-memory stage of the ARM core. It sits between the execute stage and the writeback stage and is entered once per load/store instruction, in the CPU FSM's dataMemory state. It takes the base register value, the shifted offset and the single-data-transfer control bits, then:
- forms the pre/post-indexed address;
- runs one access on the data-memory request/acknowledge port;
- returns load data, the destination-register write and the base-register writeback to the writeback stage.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_lane_align.sv | 38 +++
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 tb/tb_load_store_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Purpose: shared types and constants for the load/store unit.
// Latency: n/a (types only).
// Backpressure: n/a.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    // Access size as selected by the B bit of the transfer.
    typedef enum logic {
        SZ_WORD = 1'b0,
        SZ_BYTE = 1'b1
    } lsu_size_e;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/lsu_lane_align.sv
// Purpose: byte-lane steering for stores and lane rotate/extract for loads.
// Latency: combinational.
// Backpressure: none.
// Ports: lane/size select the lane; store_data -> be/wdata; rdata -> load_data.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  lane,
    input  lsu_size_e   size,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] rot;

    always_comb begin
        be    = BE_WORD;
        wdata = store_data;
        if (size == SZ_BYTE) begin
            be    = 4'b0001 << lane;
            wdata = {4{store_data[7:0]}};
        end

        // Rotate right by 8*lane so the addressed byte lands in bits [7:0].
        case (lane)
            2'd1:    rot = {rdata[7:0],  rdata[31:8]};
            2'd2:    rot = {rdata[15:0], rdata[31:16]};
            2'd3:    rot = {rdata[23:0], rdata[31:24]};
            default: rot = rdata;
        endcase

        load_data = (size == SZ_BYTE) ? {24'h0, rot[7:0]} : rot;
    end

endmodule

// File: rtl/load_store_unit.sv
// Purpose: multicycle data-memory stage: address generation, one req/ack access, writeback results.
// Latency: start to done in 2 cycles minimum; REQ lasts until mem_ack or TIMEOUT_CYCLES cycles.
// Backpressure: start ignored while busy; REQ held until mem_ack or timeout abort.
// Ports: execute-side operands in, mem_* request/ack port, writeback-side results out.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic        up_down,
    input  logic        pre_post,
    input  logic        byte_word,
    input  logic        load_store,
    input  logic        write_back,
    input  logic [3:0]  rd,
    input  logic [3:0]  rn,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        rd_we,
    output logic [3:0]  rd_addr,
    output logic [31:0] load_data,
    output logic        base_we,
    output logic [3:0]  base_addr,
    output logic [31:0] base_data
);

    // Counter value in the last REQ cycle allowed before abort.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state;
    logic [7:0]  tmo_cnt;
    logic [1:0]  lane_q;
    lsu_size_e   size_q;
    logic        load_q;
    logic        base_wb_q;
    logic [31:0] offset_addr_q;

    logic [31:0] offset_addr;
    logic [31:0] ea;
    logic        base_wb_next;
    logic [1:0]  align_lane;
    lsu_size_e   align_size;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] align_load;

    always_comb begin
        offset_addr  = up_down ? (base + offset) : (base - offset);
        ea           = pre_post ? offset_addr : base;
        // A load into the base register itself keeps the loaded value.
        base_wb_next = (~pre_post | write_back) & ~(load_store & (rd == rn));
        // The aligner serves the store path at launch and the load path in REQ.
        align_lane   = (state == ST_IDLE) ? ea[1:0] : lane_q;
        align_size   = (state == ST_IDLE) ? (byte_word ? SZ_BYTE : SZ_WORD) : size_q;
    end

    lsu_lane_align u_align (
        .lane       (align_lane),
        .size       (align_size),
        .store_data (store_data),
        .rdata      (mem_rdata),
        .be         (align_be),
        .wdata      (align_wdata),
        .load_data  (align_load)
    );

    always_ff @(posedge clk) begin
        if (nreset) begin
            state         <= ST_IDLE;
            tmo_cnt       <= 8'h0;
            lane_q        <= 2'b00;
            size_q        <= SZ_WORD;
            load_q        <= 1'b0;
            base_wb_q     <= 1'b0;
            offset_addr_q <= 32'h0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 32'h0;
            mem_be        <= BE_NONE;
            mem_wdata     <= 32'h0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            rd_we         <= 1'b0;
            rd_addr       <= 4'h0;
            load_data     <= 32'h0;
            base_we       <= 1'b0;
            base_addr     <= 4'h0;
            base_data     <= 32'h0;
        end else begin
            // Completion outputs are single-cycle pulses.
            done      <= 1'b0;
            err       <= 1'b0;
            rd_we     <= 1'b0;
            base_we   <= 1'b0;
            load_data <= 32'h0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state         <= ST_REQ;
                        busy          <= 1'b1;
                        tmo_cnt       <= 8'h0;
                        lane_q        <= ea[1:0];
                        size_q        <= byte_word ? SZ_BYTE : SZ_WORD;
                        load_q        <= load_store;
                        base_wb_q     <= base_wb_next;
                        offset_addr_q <= offset_addr;
                        rd_addr       <= rd;
                        base_addr     <= rn;
                        mem_req       <= 1'b1;
                        mem_we        <= ~load_store;
                        mem_addr      <= {ea[31:2], 2'b00};
                        mem_be        <= align_be;
                        mem_wdata     <= align_wdata;
                    end
                end
                ST_REQ: begin
                    // Ack takes priority over a simultaneous timeout.
                    if (mem_ack) begin
                        state     <= ST_DONE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        done      <= 1'b1;
                        rd_we     <= load_q;
                        base_we   <= base_wb_q;
                        load_data <= load_q ? align_load : 32'h0;
                        base_data <= offset_addr_q;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state   <= ST_DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose: self-checking bench for load_store_unit (vector table + scoreboard + corner sequences).
// Latency: n/a.
// Backpressure: n/a.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        nreset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base = '0, offset = '0, store_data = '0, mem_rdata = '0;
    logic        up_down = 1'b0, pre_post = 1'b0, byte_word = 1'b0;
    logic        load_store = 1'b0, write_back = 1'b0, mem_ack = 1'b0;
    logic [3:0]  rd = '0, rn = '0;
    logic        mem_req, mem_we, busy, done, err, rd_we, base_we;
    logic [31:0] mem_addr, mem_wdata, load_data, base_data;
    logic [3:0]  mem_be, rd_addr, base_addr;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(3)) dut (
        .clk(clk), .nreset(nreset), .start(start), .base(base), .offset(offset),
        .up_down(up_down), .pre_post(pre_post), .byte_word(byte_word),
        .load_store(load_store), .write_back(write_back), .rd(rd), .rn(rn),
        .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .done(done),
        .err(err), .rd_we(rd_we), .rd_addr(rd_addr), .load_data(load_data),
        .base_we(base_we), .base_addr(base_addr), .base_data(base_data)
    );

    int total = 0;
    int passed = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endfunction

    typedef struct {
        logic        err;
        logic        rd_we;
        logic        base_we;
        logic [31:0] load_data;
        logic [31:0] base_data;
        logic [3:0]  rd_addr;
        logic [3:0]  base_addr;
    } res_t;

    res_t sb[$];

    // Scoreboard: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        res_t e;
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("err", 32'(err), 32'(e.err));
                chk("rd_we", 32'(rd_we), 32'(e.rd_we));
                chk("base_we", 32'(base_we), 32'(e.base_we));
                chk("load_data", load_data, e.load_data);
                if (!e.err) begin
                    chk("base_data", base_data, e.base_data);
                    chk("rd_addr", 32'(rd_addr), 32'(e.rd_addr));
                    chk("base_addr", 32'(base_addr), 32'(e.base_addr));
                end
            end
        end
    end

    typedef struct {
        logic [31:0] base;
        logic [31:0] offset;
        logic        up, pre, bw, ls, wb;
        logic [3:0]  rd, rn;
        logic [31:0] sdata;
        int          ack_delay;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        e_we;
        logic [31:0] e_wdata;
        logic        e_rd_we, e_base_we;
        logic [31:0] e_base_data, e_load;
    } vec_t;

    vec_t vecs[7];

    task automatic drive(input vec_t v);
        base = v.base; offset = v.offset; up_down = v.up; pre_post = v.pre;
        byte_word = v.bw; load_store = v.ls; write_back = v.wb;
        rd = v.rd; rn = v.rn; store_data = v.sdata;
    endtask

    task automatic run_vec(input vec_t v);
        res_t e;
        @(negedge clk);
        drive(v);
        start = 1'b1;
        e = '{1'b0, v.e_rd_we, v.e_base_we, v.e_load, v.e_base_data, v.rd, v.rn};
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("mem_req", 32'(mem_req), 32'h1);
        chk("busy", 32'(busy), 32'h1);
        chk("mem_addr", mem_addr, v.e_addr);
        chk("mem_be", 32'(mem_be), 32'(v.e_be));
        chk("mem_we", 32'(mem_we), 32'(v.e_we));
        chk("mem_wdata", mem_wdata, v.e_wdata);
        for (int i = 0; i < v.ack_delay; i++) begin
            @(negedge clk);
            chk("req_held", 32'(mem_req), 32'h1);
            chk("addr_held", mem_addr, v.e_addr);
        end
        mem_ack = 1'b1;
        mem_rdata = v.rdata;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
        chk("done_pulse", 32'(done), 32'h1);
        chk("req_dropped", 32'(mem_req), 32'h0);
        @(negedge clk);
        chk("done_single", 32'(done), 32'h0);
        chk("busy_clear", 32'(busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        res_t e;
        int   done_cnt;
        //          base        offset     up   pre  bw   ls   wb   rd  rn   sdata         dly rdata
        //          e_addr        e_be     we   e_wdata       rd_we bwe  base_data     load
        vecs[0] = '{32'h100, 32'h4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 32'h0, 0, 32'hDEADBEEF,
                    32'h104, 4'b1111, 1'b0, 32'h0, 1'b1, 1'b0, 32'h104, 32'hDEADBEEF};
        vecs[1] = '{32'h203, 32'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd5, 32'h1234565A, 0, 32'h0,
                    32'h200, 4'b1000, 1'b1, 32'h5A5A5A5A, 1'b0, 1'b1, 32'h200, 32'h0};
        // Ack arrives in the third REQ cycle, same cycle as the timeout threshold.
        vecs[2] = '{32'h100, 32'h2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 4'd2, 32'h0, 2, 32'h11223344,
                    32'h100, 4'b1111, 1'b0, 32'h0, 1'b1, 1'b1, 32'h102, 32'h33441122};
        vecs[3] = '{32'h40, 32'h8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 4'd4, 32'h0, 1, 32'hCAFEF00D,
                    32'h48, 4'b1111, 1'b0, 32'h0, 1'b1, 1'b0, 32'h48, 32'hCAFEF00D};
        vecs[4] = '{32'h301, 32'h10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 4'd8, 32'h0, 0, 32'hAABBCCDD,
                    32'h300, 4'b0010, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2F1, 32'hCC};
        vecs[5] = '{32'h4, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 4'd9, 32'h87654321, 0, 32'h0,
                    32'hFFFFFFFC, 4'b1111, 1'b1, 32'h87654321, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h0};
        vecs[6] = '{32'h1000, 32'h6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd3, 32'hC3, 0, 32'h0,
                    32'h1004, 4'b0100, 1'b1, 32'hC3C3C3C3, 1'b0, 1'b0, 32'h1006, 32'h0};

        repeat (3) @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", 32'(mem_be), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done_err", {30'h0, done, err}, 32'h0);
        chk("rst_we", {30'h0, rd_we, base_we}, 32'h0);
        chk("rst_data", load_data | base_data, 32'h0);
        chk("rst_addrs", {24'h0, rd_addr, base_addr}, 32'h0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Timeout: no ack, REQ lasts 3 cycles, a start during busy is ignored.
        @(negedge clk);
        drive(vecs[0]);
        write_back = 1'b1;
        start = 1'b1;
        e = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'd1, 4'd2};
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("tmo_req1", 32'(mem_req), 32'h1);
        base = 32'h5000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("tmo_req2", 32'(mem_req), 32'h1);
        @(negedge clk);
        chk("tmo_req3", 32'(mem_req), 32'h1);
        chk("tmo_addr_held", mem_addr, 32'h104);
        @(negedge clk);
        chk("tmo_done", 32'(done), 32'h1);
        chk("tmo_req_off", 32'(mem_req), 32'h0);
        @(negedge clk);
        chk("tmo_idle", 32'(busy), 32'h0);
        @(negedge clk);
        chk("tmo_no_relaunch", 32'(mem_req), 32'h0);

        // Reset in the second REQ cycle: back to idle, no done pulse.
        @(negedge clk);
        drive(vecs[1]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rma_req1", 32'(mem_req), 32'h1);
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        nreset = 1'b0;
        chk("rma_req_off", 32'(mem_req), 32'h0);
        chk("rma_busy_off", 32'(busy), 32'h0);
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || rd_we || base_we) done_cnt++;
        end
        chk("rma_no_done", 32'(done_cnt), 32'h0);

        // Ack outside REQ is ignored, then a normal access still works.
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray_ack", 32'(done), 32'h0);
        run_vec(vecs[4]);

        @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
